depthwise_conv_stream: RTL and testbench
========================================

Name: depthwise_conv_stream

Overview:
- Streaming depthwise 2-D convolution stage of the MNIST CNN datapath. Sits between the zero-padding stage and the pointwise (1x1) stage.
- Accepts one pre-padded pixel per cycle, all channels in parallel, in raster order.
- Each channel is convolved with its own KxK kernel; per-channel bias, shift and saturation are applied.
- Emits one output pixel (all channels) per valid window position.

Parameters:
- N, 16: data/weight width, signed two's complement.
- INPUT_CHANNEL, 3: channel count (input = output channels).
- INPUT_SIZE, 6: square frame side, already padded.
- KERNEL_SIZE, 3: kernel side K.
- STRIDE, 1: window step in rows and columns.
- PADDING, 0: accepted for interface compatibility; ignored (padding is done upstream).
- DILATION, 1: kernel tap spacing.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: synchronous, active-high reset (asserted when 1).
- ce, input, 1: global clock enable; 0 freezes all state.
- input_vld, input, 1: input_din valid this cycle.
- input_din, input, INPUT_CHANNEL*N: channel c at [c*N +: N].
- weight_din, input, INPUT_CHANNEL*K*K*N: tap (c, ky, kx) at [(c*K*K + ky*K + kx)*N +: N].
- bias_din, input, INPUT_CHANNEL*32: signed bias for channel c at [c*32 +: 32].
- shift_din, input, INPUT_CHANNEL*5: unsigned right-shift for channel c at [c*5 +: 5].
- conv_dout, output, INPUT_CHANNEL*N: result; same channel packing as input_din.
- conv_dout_vld, output, 1: conv_dout valid.
- conv_dout_end, output, 1: marks the last output pixel of a frame.

Behaviour:
- Reset: row/col counters, line buffers, window registers and pipeline registers all clear. conv_dout=0, conv_dout_vld=0, conv_dout_end=0.
- Reset mid-frame discards the partial frame. The next accepted pixel is (row 0, col 0).
- Acceptance: a pixel is accepted when ce=1 and input_vld=1. No backpressure; the source may insert gaps freely.
- Counters: col advances 0..INPUT_SIZE-1, then wraps and row advances. After pixel (INPUT_SIZE-1, INPUT_SIZE-1), both wrap to 0. Back-to-back frames need no idle cycle.
- Window geometry:
  - Span S = DILATION*(K-1)+1.
  - OUT = (INPUT_SIZE - S)/STRIDE + 1 per side (integer division).
  - Window (oy, ox) covers input rows oy*STRIDE + ky*DILATION and columns ox*STRIDE + kx*DILATION, for ky, kx in 0..K-1.
- Buffering: line buffers hold S-1 previous rows per channel. A window fires when the accepted pixel is its bottom-right tap, i.e. row >= S-1, col >= S-1, and (row-(S-1)) and (col-(S-1)) are both multiples of STRIDE.
- Arithmetic, per channel:
  - acc = sum over taps of (x * w), each product a signed 2N-bit value, accumulated in 32-bit signed; then acc = acc + bias.
  - y = acc >>> shift (arithmetic shift).
  - y saturates to the signed N-bit range: above max -> 0x7FFF, below min -> 0x8000 for N=16.
- Latency: conv_dout_vld asserts exactly 2 ce-active cycles after the cycle that accepted the firing pixel (stage 1: products; stage 2: sum, bias, shift, saturate).
- Output valid: one-cycle pulse per window; OUT*OUT pulses per frame.
- End flag: conv_dout_end asserts together with conv_dout_vld on the last window of the frame, and is 0 otherwise.
- conv_dout holds its last value between pulses.
- ce=0 freezes all registers. While ce=0, conv_dout_vld and conv_dout_end outputs read 0 (the registered flags are gated by ce), so a pulse is never counted twice.
- Weights, bias and shift are sampled combinationally in stage 1 and must be stable during a frame.

Test Plan:
- Defaults: all inputs 1, all weights 1, bias 0, shift 0 -> 16 outputs, each channel = 9. conv_dout_end on the 16th only; first vld 2 cycles after input pixel (2,2) is accepted.
- Ramp: ch0 input = row*6+col; centre weight 1, others 0 -> output (oy, ox) = (oy+1)*6+(ox+1), i.e. 7, 8, 9, 10, 13, ..., 28 in raster order.
- Bias/shift: weights 0, bias 32, shift 2 -> every output 8. Bias -32, shift 2 -> every output -8 (0xFFF8).
- Saturation: inputs and weights 0x7FFF, shift 0 -> 0x7FFF. Inputs 0x8001, weights 0x7FFF -> 0x8000.
- STRIDE=2 (or DILATION=2) with size 6: STRIDE=2 gives 2x2 outputs, centre-tap ramp values 7, 9, 19, 21. DILATION=2 gives 2x2 outputs, centre-tap values 14, 15, 20, 21. conv_dout_end on the 4th output.
- Gaps and stall: random input_vld gaps, ce low for 5 cycles mid-frame, and two back-to-back frames -> identical output sequence to the gap-free run, exactly 16 vld per frame. Reset asserted mid-frame -> no outputs until a fresh full frame.

Source files
------------

// File: rtl/depthwise_conv_stream.sv
// Streaming depthwise KxK convolution: one pre-padded pixel per cycle, all channels
// in parallel, raster order. Each channel has its own kernel, bias, shift and saturation.
// Two pipeline stages after acceptance: tap products, then sum/bias/shift/saturate.
module depthwise_conv_stream #(
    parameter int N             = 16,
    parameter int INPUT_CHANNEL = 3,
    parameter int INPUT_SIZE    = 6,
    parameter int KERNEL_SIZE   = 3,
    parameter int STRIDE        = 1,
    parameter int PADDING       = 0,
    parameter int DILATION      = 1
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             ce,
    input  logic                                             input_vld,
    input  logic [INPUT_CHANNEL*N-1:0]                       input_din,
    input  logic [INPUT_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*N-1:0] weight_din,
    input  logic [INPUT_CHANNEL*32-1:0]                      bias_din,
    input  logic [INPUT_CHANNEL*5-1:0]                       shift_din,
    output logic [INPUT_CHANNEL*N-1:0]                       conv_dout,
    output logic                                             conv_dout_vld,
    output logic                                             conv_dout_end
);
    localparam int K    = KERNEL_SIZE;
    localparam int KK   = K * K;
    localparam int S    = DILATION * (K - 1) + 1;          // window span in pixels
    localparam int OUT  = (INPUT_SIZE - S) / STRIDE + 1;   // outputs per side
    localparam int LAST = (S - 1) + (OUT - 1) * STRIDE;    // bottom-right tap of the last window
    localparam int CW   = $clog2(INPUT_SIZE);
    localparam int PW   = 2 * N;
    localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (N - 1)) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (N - 1));

    // Padding is performed upstream; the parameter only keeps the interface uniform.
    if (PADDING != 0) begin : g_padding_ignored
    end

    logic [CW-1:0] row_reg, col_reg;
    logic          s1_vld_reg, s1_end_reg, vld_reg, end_reg;
    logic          accept, row_ok, col_ok, fire, is_last;

    assign accept  = ce & input_vld;
    assign row_ok  = (int'(row_reg) >= S - 1) && (((int'(row_reg) - (S - 1)) % STRIDE) == 0);
    assign col_ok  = (int'(col_reg) >= S - 1) && (((int'(col_reg) - (S - 1)) % STRIDE) == 0);
    assign fire    = accept & row_ok & col_ok;
    assign is_last = (int'(row_reg) == LAST) && (int'(col_reg) == LAST);

    // Raster position counters and the valid/end flags travelling with the pipeline.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            row_reg    <= '0;
            col_reg    <= '0;
            s1_vld_reg <= 1'b0;
            s1_end_reg <= 1'b0;
            vld_reg    <= 1'b0;
            end_reg    <= 1'b0;
        end else if (ce) begin
            if (input_vld) begin
                if (int'(col_reg) == INPUT_SIZE - 1) begin
                    col_reg <= '0;
                    row_reg <= (int'(row_reg) == INPUT_SIZE - 1) ? '0 : row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end
            s1_vld_reg <= fire;
            s1_end_reg <= fire & is_last;
            vld_reg    <= s1_vld_reg;
            end_reg    <= s1_end_reg;
        end
    end

    // Flags are frozen while ce=0, so mask them to avoid a pulse being seen twice.
    assign conv_dout_vld = vld_reg & ce;
    assign conv_dout_end = end_reg & ce;

    for (genvar gi = 0; gi < INPUT_CHANNEL; gi++) begin : g_ch
        logic signed [N-1:0]  lb_reg  [S-1][INPUT_SIZE];  // row r holds input row (current - (S-1) + r)
        logic signed [N-1:0]  win_reg [S][S-1];           // previous S-1 columns of the window
        logic signed [N-1:0]  view    [S][S];             // full window with the live column on the right
        logic signed [PW-1:0] prod_reg [KK];
        logic signed [31:0]   bias_reg;
        logic [4:0]           shift_reg;
        logic signed [31:0]   acc, shifted;
        logic [N-1:0]         sat;
        logic [N-1:0]         dout_reg;
        logic signed [N-1:0]  pix;

        assign pix = $signed(input_din[gi*N +: N]);

        // Assemble the window as seen once the current pixel is taken into account.
        always_comb begin
            for (int r = 0; r < S; r++) begin
                for (int j = 0; j < S - 1; j++) begin
                    view[r][j] = win_reg[r][j];
                end
            end
            for (int r = 0; r < S - 1; r++) begin
                view[r][S-1] = lb_reg[r][col_reg];
            end
            view[S-1][S-1] = pix;
        end

        // Shift the column into the line buffers and slide the window left by one.
        always_ff @(posedge clk) begin
            if (rst_n) begin
                lb_reg  <= '{default: '0};
                win_reg <= '{default: '0};
            end else if (accept) begin
                for (int r = 0; r < S - 1; r++) begin
                    lb_reg[r][col_reg] <= view[r+1][S-1];
                end
                for (int r = 0; r < S; r++) begin
                    for (int j = 0; j < S - 1; j++) begin
                        win_reg[r][j] <= view[r][j+1];
                    end
                end
            end
        end

        // Stage 1: per-tap products at dilated positions, with bias/shift sampled alongside.
        always_ff @(posedge clk) begin
            if (rst_n) begin
                prod_reg  <= '{default: '0};
                bias_reg  <= '0;
                shift_reg <= '0;
            end else if (fire) begin
                for (int ky = 0; ky < K; ky++) begin
                    for (int kx = 0; kx < K; kx++) begin
                        prod_reg[ky*K+kx] <= PW'(view[ky*DILATION][kx*DILATION])
                                           * PW'($signed(weight_din[(gi*KK + ky*K + kx)*N +: N]));
                    end
                end
                bias_reg  <= $signed(bias_din[gi*32 +: 32]);
                shift_reg <= shift_din[gi*5 +: 5];
            end
        end

        // Stage 2 datapath: 32-bit wrapping sum plus bias, arithmetic shift, saturate.
        always_comb begin
            acc = bias_reg;
            for (int t = 0; t < KK; t++) begin
                acc = acc + 32'(prod_reg[t]);
            end
            shifted = acc >>> shift_reg;
            if (shifted > SAT_MAX) begin
                sat = SAT_MAX[N-1:0];
            end else if (shifted < SAT_MIN) begin
                sat = SAT_MIN[N-1:0];
            end else begin
                sat = shifted[N-1:0];
            end
        end

        // Stage 2 register: result holds between output pulses.
        always_ff @(posedge clk) begin
            if (rst_n) begin
                dout_reg <= '0;
            end else if (ce && s1_vld_reg) begin
                dout_reg <= sat;
            end
        end

        assign conv_dout[gi*N +: N] = dout_reg;
    end

endmodule

// File: tb/tb_depthwise_conv_stream.sv
// Bench for depthwise_conv_stream: three instances (base, stride 2, dilation 2) share one
// input stream; a frame-level convolution model fills expected queues that one compare
// process checks on every output pulse.
module tb_depthwise_conv_stream;
    localparam int N  = 16;
    localparam int C  = 3;
    localparam int SZ = 6;
    localparam int K  = 3;

    typedef struct {
        logic [C*N-1:0] data;
        bit             last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;   // active-high reset
    logic                 ce, input_vld;
    logic [C*N-1:0]       input_din;
    logic [C*K*K*N-1:0]   weight_din;
    logic [C*32-1:0]      bias_din;
    logic [C*5-1:0]       shift_din;
    logic [C*N-1:0]       dout0, dout1, dout2;
    logic                 vld0, vld1, vld2, end0, end1, end2;

    depthwise_conv_stream #(.N(N), .INPUT_CHANNEL(C), .INPUT_SIZE(SZ), .KERNEL_SIZE(K),
                            .STRIDE(1), .PADDING(0), .DILATION(1)) u_base (
        .clk(clk), .rst_n(rst_n), .ce(ce), .input_vld(input_vld), .input_din(input_din),
        .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din),
        .conv_dout(dout0), .conv_dout_vld(vld0), .conv_dout_end(end0));

    depthwise_conv_stream #(.N(N), .INPUT_CHANNEL(C), .INPUT_SIZE(SZ), .KERNEL_SIZE(K),
                            .STRIDE(2), .PADDING(0), .DILATION(1)) u_str (
        .clk(clk), .rst_n(rst_n), .ce(ce), .input_vld(input_vld), .input_din(input_din),
        .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din),
        .conv_dout(dout1), .conv_dout_vld(vld1), .conv_dout_end(end1));

    depthwise_conv_stream #(.N(N), .INPUT_CHANNEL(C), .INPUT_SIZE(SZ), .KERNEL_SIZE(K),
                            .STRIDE(1), .PADDING(0), .DILATION(2)) u_dil (
        .clk(clk), .rst_n(rst_n), .ce(ce), .input_vld(input_vld), .input_din(input_din),
        .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din),
        .conv_dout(dout2), .conv_dout_vld(vld2), .conv_dout_end(end2));

    // Frame contents and coefficients the model works from.
    logic signed [N-1:0] pix [C][SZ][SZ];
    logic signed [N-1:0] wt  [C][K][K];
    int                  bias [C];
    int                  shf  [C];

    exp_t q0[$], q1[$], q2[$];
    int   b0, b1, b2;
    int   checks = 0, errors = 0;
    int   cyc = 0;
    int   n0 = 0, n1 = 0, n2 = 0;
    int   first_vld_cyc = -1, accept_cyc = -1;
    bit   record_accept = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: full convolution of the stored frame at window (oy, ox).
    function automatic logic [C*N-1:0] model_px(int st, int dl, int oy, int ox);
        logic [C*N-1:0] res = '0;
        for (int c = 0; c < C; c++) begin
            int acc = 0;
            int y;
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++)
                    acc += int'(pix[c][oy*st+ky*dl][ox*st+kx*dl]) * int'(wt[c][ky][kx]);
            acc += bias[c];
            y = acc >>> shf[c];
            if (y > 32767) y = 32767;
            else if (y < -32768) y = -32768;
            res[c*N +: N] = y[N-1:0];
        end
        return res;
    endfunction

    task automatic build_expected();
        int st[3] = '{1, 2, 1};
        int dl[3] = '{1, 1, 2};
        b0 = q0.size(); b1 = q1.size(); b2 = q2.size();
        for (int k = 0; k < 3; k++) begin
            int span = dl[k] * (K - 1) + 1;
            int outn = (SZ - span) / st[k] + 1;
            for (int oy = 0; oy < outn; oy++)
                for (int ox = 0; ox < outn; ox++) begin
                    exp_t e;
                    e.data = model_px(st[k], dl[k], oy, ox);
                    e.last = (oy == outn - 1) && (ox == outn - 1);
                    case (k)
                        0: q0.push_back(e);
                        1: q1.push_back(e);
                        default: q2.push_back(e);
                    endcase
                end
        end
    endtask

    // Hand-computed literal pinning a model entry: queue k, frame-relative index i, channel ch.
    task automatic pin(input string name, input int k, input int i, input int ch, input logic [15:0] val);
        exp_t e;
        case (k)
            0: e = q0[b0+i];
            1: e = q1[b1+i];
            default: e = q2[b2+i];
        endcase
        check(name, 64'(e.data[ch*N +: N]), 64'(val));
    endtask

    task automatic load_frame(input int mode);
        for (int c = 0; c < C; c++) begin
            for (int r = 0; r < SZ; r++)
                for (int x = 0; x < SZ; x++) begin
                    case (mode)
                        0: pix[c][r][x] = 16'sd1;
                        3: pix[c][r][x] = (c == 0) ? 16'sh7FFF : (c == 1) ? 16'sh8001 : N'((r*6+x)*500);
                        default: pix[c][r][x] = (c == 0) ? N'(r*6+x) : (c == 1) ? N'(r*6+x-20) : N'(r*x*50);
                    endcase
                end
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++) begin
                    case (mode)
                        0: wt[c][ky][kx] = 16'sd1;
                        2: wt[c][ky][kx] = 16'sd0;
                        3: wt[c][ky][kx] = (c == 2) ? 16'sd1 : 16'sh7FFF;
                        default: wt[c][ky][kx] = (c == 0) ? ((ky == 1 && kx == 1) ? 16'sd1 : 16'sd0)
                                                : (c == 1) ? N'(ky*3+kx-4) : 16'sd3;
                    endcase
                end
            case (mode)
                1: begin bias[c] = (c == 0) ? 0 : (c == 1) ? 5 : -100; shf[c] = c; end
                2: begin bias[c] = (c == 0) ? 32 : (c == 1) ? -32 : 1000; shf[c] = (c == 2) ? 3 : 2; end
                default: begin bias[c] = 0; shf[c] = 0; end
            endcase
        end
        for (int c = 0; c < C; c++) begin
            for (int t = 0; t < K*K; t++) weight_din[(c*K*K + t)*N +: N] = wt[c][t/K][t%K];
            bias_din[c*32 +: 32] = bias[c];
            shift_din[c*5 +: 5]  = shf[c][4:0];
        end
    endtask

    function automatic logic [C*N-1:0] pack_pix(int r, int x);
        logic [C*N-1:0] v;
        for (int c = 0; c < C; c++) v[c*N +: N] = pix[c][r][x];
        return v;
    endfunction

    task automatic send_frame(input bit gaps, input bit stall, input int npix);
        for (int i = 0; i < npix; i++) begin
            int r = i / SZ;
            int x = i % SZ;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    input_vld = 1'b0;
                    input_din = {C{16'hDEAD}};
                    @(posedge clk); #1;
                end
            end
            if (stall && i == 20) begin
                ce = 1'b0;
                input_vld = 1'b1;
                input_din = {C{16'hBEEF}};
                repeat (5) begin @(posedge clk); #1; end
                ce = 1'b1;
            end
            input_din = pack_pix(r, x);
            input_vld = 1'b1;
            if (record_accept && i == 14) accept_cyc = cyc;
            @(posedge clk); #1;
            input_vld = 1'b0;
        end
    endtask

    // Single compare process: every pulse is checked against the model queues; ce=0 must mask flags.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_t e;
            if (!ce) check("ce_gate_flags", 64'({vld0, vld1, vld2, end0, end1, end2}), 64'd0);
            if (vld0) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                n0++;
                if (q0.size() == 0) check("unexpected_out_base", 64'(dout0), 64'd0 - 64'd1);
                else begin e = q0.pop_front(); check("out_base", 64'({end0, dout0}), 64'({e.last, e.data})); end
            end
            if (vld1) begin
                n1++;
                if (q1.size() == 0) check("unexpected_out_stride", 64'(dout1), 64'd0 - 64'd1);
                else begin e = q1.pop_front(); check("out_stride", 64'({end1, dout1}), 64'({e.last, e.data})); end
            end
            if (vld2) begin
                n2++;
                if (q2.size() == 0) check("unexpected_out_dil", 64'(dout2), 64'd0 - 64'd1);
                else begin e = q2.pop_front(); check("out_dil", 64'({end2, dout2}), 64'({e.last, e.data})); end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; ce = 1'b1; input_vld = 1'b0; input_din = '0;
        load_frame(0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", 64'(dout0), 64'd0);
        check("reset_flags", 64'({vld0, end0, vld1, vld2}), 64'd0);
        rst_n = 1'b0;

        // Frame 1: defaults, every output 9, end on the 16th.
        build_expected();
        pin("pin_default_ch0", 0, 0, 0, 16'd9);
        pin("pin_default_ch2", 0, 15, 2, 16'd9);
        check("pin_default_count", 64'(q0.size() - b0), 64'd16);
        record_accept = 1'b1;
        send_frame(1'b0, 1'b0, SZ*SZ);
        record_accept = 1'b0;

        // Frame 2: ramp, centre-tap pins for all three geometries.
        load_frame(1);
        build_expected();
        pin("pin_ramp_first", 0, 0, 0, 16'd7);
        pin("pin_ramp_fifth", 0, 4, 0, 16'd13);
        pin("pin_ramp_last", 0, 15, 0, 16'd28);
        pin("pin_stride_1", 1, 1, 0, 16'd9);
        pin("pin_stride_2", 1, 2, 0, 16'd19);
        pin("pin_dil_0", 2, 0, 0, 16'd14);
        pin("pin_dil_3", 2, 3, 0, 16'd21);
        send_frame(1'b0, 1'b0, SZ*SZ);

        // Frame 3: bias and shift only.
        load_frame(2);
        build_expected();
        pin("pin_bias_pos", 0, 0, 0, 16'd8);
        pin("pin_bias_neg", 0, 7, 1, 16'hFFF8);
        pin("pin_bias_ch2", 0, 3, 2, 16'd125);
        send_frame(1'b0, 1'b0, SZ*SZ);

        // Frame 4: saturation both ways.
        load_frame(3);
        build_expected();
        pin("pin_sat_max", 0, 0, 0, 16'h7FFF);
        pin("pin_sat_min", 0, 0, 1, 16'h8000);
        pin("pin_sat_ch2_first", 0, 0, 2, 16'd31500);
        send_frame(1'b0, 1'b0, SZ*SZ);

        // Frames 5 and 6: ramp with gaps and a ce stall, then back-to-back gap-free.
        load_frame(1);
        build_expected();
        send_frame(1'b1, 1'b1, SZ*SZ);
        build_expected();
        send_frame(1'b0, 1'b0, SZ*SZ);
        repeat (10) @(posedge clk);
        #1;
        check("latency_first_vld", 64'(first_vld_cyc - accept_cyc), 64'd2);

        // Partial frame, reset mid-frame, then a fresh full frame.
        send_frame(1'b0, 1'b0, 14);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midreset_dout", 64'({dout0, dout1}), 64'd0);
        check("midreset_flags", 64'({vld0, end0}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        build_expected();
        send_frame(1'b0, 1'b0, SZ*SZ);
        repeat (10) @(posedge clk);
        #1;

        check("q_base_drained", 64'(q0.size()), 64'd0);
        check("q_stride_drained", 64'(q1.size()), 64'd0);
        check("q_dil_drained", 64'(q2.size()), 64'd0);
        check("count_base", 64'(n0), 64'd112);
        check("count_stride", 64'(n1), 64'd28);
        check("count_dil", 64'(n2), 64'd28);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
